column_frame_scheduler: RTL and testbench

- Sequences host writes into the triple-buffered column store that feeds the VGA column renderer.
- Assembles each column record from five 16-bit bus words and issues one write strobe per column to the active write buffer, tracking the column index.
- Rotates buffer roles (write / read / spare) on frame completion and at the vertical-blank swap point, so the renderer never reads a partially written frame.

---
 rtl/col_pkg.sv | 45 ++++
 rtl/col_word_assembler.sv | 50 +++++
 rtl/column_frame_scheduler.sv | 110 +++++++++++
 tb/tb_column_frame_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/col_pkg.sv
// rtl/col_pkg.sv - shared constants and record layout for the column frame scheduler
package col_pkg;

  localparam int NUM_COLS      = 640;
  localparam int WORDS_PER_COL = 5;
  localparam int COLNUM_W      = 10;
  localparam int COLDATA_W     = 42;
  localparam int SFDATA_W      = 32;

  // Field offsets inside the packed record, shared with the column renderer.
  localparam int CD_W0_LSB = 0;
  localparam int CD_W1_LSB = 10;
  localparam int CD_W2_LSB = 26;
  localparam int SF_W4_LSB = 0;
  localparam int SF_W3_LSB = 16;

  typedef logic [1:0] buf_idx_t;

  typedef struct packed {
    logic [COLDATA_W-1:0] coldata;
    logic [SFDATA_W-1:0]  sfdata;
  } col_rec_t;

  function automatic col_rec_t pack_rec(
    input logic [9:0]  w0,
    input logic [15:0] w1,
    input logic [15:0] w2,
    input logic [15:0] w3,
    input logic [15:0] w4
  );
    col_rec_t r;
    r = '0;
    r.coldata[CD_W0_LSB +: 10] = w0;
    r.coldata[CD_W1_LSB +: 16] = w1;
    r.coldata[CD_W2_LSB +: 16] = w2;
    r.sfdata[SF_W4_LSB +: 16]  = w4;
    r.sfdata[SF_W3_LSB +: 16]  = w3;
    return r;
  endfunction

  function automatic logic [2:0] buf_onehot(input buf_idx_t idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/col_word_assembler.sv
// rtl/col_word_assembler.sv - collects five bus words into one column record
module col_word_assembler
  import col_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_word_valid,
  input  logic [15:0] i_wr_word,
  input  logic        i_col_restart,
  output logic        o_complete,
  output col_rec_t    o_rec
);

  localparam logic [2:0] LAST_STAGE = 3'(WORDS_PER_COL - 1);

  logic [2:0]  r_stage;
  logic [9:0]  r_w0;
  logic [15:0] r_w1;
  logic [15:0] r_w2;
  logic [15:0] r_w3;
  logic        w_last_stage;

  assign w_last_stage = (r_stage == LAST_STAGE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stage <= '0;
      r_w0    <= '0;
      r_w1    <= '0;
      r_w2    <= '0;
      r_w3    <= '0;
    end else if (i_col_restart) begin
      r_stage <= '0;
    end else if (i_word_valid) begin
      case (r_stage)
        3'd0:    r_w0 <= i_wr_word[9:0];
        3'd1:    r_w1 <= i_wr_word;
        3'd2:    r_w2 <= i_wr_word;
        3'd3:    r_w3 <= i_wr_word;
        default: ;
      endcase
      r_stage <= w_last_stage ? 3'd0 : r_stage + 3'd1;
    end
  end

  // The final word is used straight off the bus so the write strobe lands one cycle later.
  assign o_complete = i_word_valid & ~i_col_restart & w_last_stage;
  assign o_rec      = pack_rec(r_w0, r_w1, r_w2, r_w3, i_wr_word);

endmodule

// File: rtl/column_frame_scheduler.sv
// rtl/column_frame_scheduler.sv - column write sequencing and triple-buffer role rotation
module column_frame_scheduler
  import col_pkg::*;
#(
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  word_valid,
  input  logic [15:0]           wr_word,
  input  logic                  col_restart,
  input  logic                  swap_strobe,
  output logic [2:0]            buf_we,
  output logic [COLNUM_W-1:0]   wr_colnum,
  output logic [COLDATA_W-1:0]  wr_coldata,
  output logic [SFDATA_W-1:0]   wr_sfdata,
  output logic [1:0]            rd_idx,
  output logic [1:0]            wr_idx,
  output logic                  frame_pending,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam logic [COLNUM_W-1:0] LAST_COL = COLNUM_W'(NUM_COLS - 1);

  logic                  w_complete;
  col_rec_t              w_rec;

  logic [2:0]            r_buf_we;
  logic [COLNUM_W-1:0]   r_wr_colnum;
  logic [COLDATA_W-1:0]  r_wr_coldata;
  logic [SFDATA_W-1:0]   r_wr_sfdata;
  logic [COLNUM_W-1:0]   r_colnum;
  logic                  r_frame_end;
  buf_idx_t              r_rd_idx;
  buf_idx_t              r_wr_idx;
  buf_idx_t              r_spare_idx;
  logic                  r_frame_pending;
  logic [DROP_CNT_W-1:0] r_drop_count;

  col_word_assembler u_asm (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_word_valid  (word_valid),
    .i_wr_word     (wr_word),
    .i_col_restart (col_restart),
    .o_complete    (w_complete),
    .o_rec         (w_rec)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf_we     <= '0;
      r_wr_colnum  <= '0;
      r_wr_coldata <= '0;
      r_wr_sfdata  <= '0;
      r_colnum     <= '0;
      r_frame_end  <= 1'b0;
    end else begin
      r_buf_we    <= w_complete ? buf_onehot(r_wr_idx) : 3'b000;
      r_frame_end <= w_complete && (r_colnum == LAST_COL);
      if (col_restart) begin
        r_colnum <= '0;
      end else if (w_complete) begin
        r_wr_colnum  <= r_colnum;
        r_wr_coldata <= w_rec.coldata;
        r_wr_sfdata  <= w_rec.sfdata;
        r_colnum     <= (r_colnum == LAST_COL) ? '0 : r_colnum + COLNUM_W'(1);
      end
    end
  end

  // Rotation runs the cycle after the last column write, so that write still hits the old buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_idx        <= 2'd0;
      r_wr_idx        <= 2'd1;
      r_spare_idx     <= 2'd2;
      r_frame_pending <= 1'b0;
      r_drop_count    <= '0;
    end else begin
      if (r_frame_end && swap_strobe) begin
        r_rd_idx        <= r_wr_idx;
        r_wr_idx        <= r_spare_idx;
        r_spare_idx     <= r_rd_idx;
        r_frame_pending <= 1'b0;
      end else if (r_frame_end) begin
        r_wr_idx        <= r_spare_idx;
        r_spare_idx     <= r_wr_idx;
        r_frame_pending <= 1'b1;
      end else if (swap_strobe && r_frame_pending) begin
        r_rd_idx        <= r_spare_idx;
        r_spare_idx     <= r_rd_idx;
        r_frame_pending <= 1'b0;
      end
      if (r_frame_end && r_frame_pending && (r_drop_count != {DROP_CNT_W{1'b1}})) begin
        r_drop_count <= r_drop_count + DROP_CNT_W'(1);
      end
    end
  end

  assign buf_we        = r_buf_we;
  assign wr_colnum     = r_wr_colnum;
  assign wr_coldata    = r_wr_coldata;
  assign wr_sfdata     = r_wr_sfdata;
  assign rd_idx        = r_rd_idx;
  assign wr_idx        = r_wr_idx;
  assign frame_pending = r_frame_pending;
  assign drop_count    = r_drop_count;

endmodule

// File: tb/tb_column_frame_scheduler.sv
// tb/tb_column_frame_scheduler.sv - self-checking bench for column_frame_scheduler
module tb_column_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        word_valid;
  logic [15:0] wr_word;
  logic        col_restart;
  logic        swap_strobe;
  logic [2:0]  buf_we;
  logic [9:0]  wr_colnum;
  logic [41:0] wr_coldata;
  logic [31:0] wr_sfdata;
  logic [1:0]  rd_idx;
  logic [1:0]  wr_idx;
  logic        frame_pending;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  column_frame_scheduler #(.DROP_CNT_W(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .word_valid    (word_valid),
    .wr_word       (wr_word),
    .col_restart   (col_restart),
    .swap_strobe   (swap_strobe),
    .buf_we        (buf_we),
    .wr_colnum     (wr_colnum),
    .wr_coldata    (wr_coldata),
    .wr_sfdata     (wr_sfdata),
    .rd_idx        (rd_idx),
    .wr_idx        (wr_idx),
    .frame_pending (frame_pending),
    .drop_count    (drop_count)
  );

  typedef struct {
    logic [4:0][15:0] w;
    logic [41:0]      cd;
    logic [31:0]      sf;
  } vec_t;

  typedef struct {
    logic [2:0]  we;
    logic [9:0]  col;
    logic [41:0] cd;
    logic [31:0] sf;
  } exp_t;

  vec_t vecs [4];
  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      chk("role_perm", 64'((rd_idx != wr_idx) && (rd_idx != dut.r_spare_idx) &&
          (wr_idx != dut.r_spare_idx) && (rd_idx < 2'd3) && (wr_idx < 2'd3) &&
          (dut.r_spare_idx < 2'd3)), 64'(1));
      if (buf_we != 3'b000) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", 64'(buf_we), 64'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("buf_we", 64'(buf_we), 64'(e.we));
          chk("wr_colnum", 64'(wr_colnum), 64'(e.col));
          chk("wr_coldata", 64'(wr_coldata), 64'(e.cd));
          chk("wr_sfdata", 64'(wr_sfdata), 64'(e.sf));
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_buf_we"}, 64'(buf_we), 64'(0));
    chk({tag, "_wr_colnum"}, 64'(wr_colnum), 64'(0));
    chk({tag, "_wr_coldata"}, 64'(wr_coldata), 64'(0));
    chk({tag, "_wr_sfdata"}, 64'(wr_sfdata), 64'(0));
    chk({tag, "_rd_idx"}, 64'(rd_idx), 64'(0));
    chk({tag, "_wr_idx"}, 64'(wr_idx), 64'(1));
    chk({tag, "_spare_idx"}, 64'(dut.r_spare_idx), 64'(2));
    chk({tag, "_frame_pending"}, 64'(frame_pending), 64'(0));
    chk({tag, "_drop_count"}, 64'(drop_count), 64'(0));
  endtask

  task automatic check_roles(input string tag, input logic [1:0] rd, input logic [1:0] wr,
                             input logic [1:0] sp, input logic pend, input logic [7:0] drops);
    chk({tag, "_rd_idx"}, 64'(rd_idx), 64'(rd));
    chk({tag, "_wr_idx"}, 64'(wr_idx), 64'(wr));
    chk({tag, "_spare_idx"}, 64'(dut.r_spare_idx), 64'(sp));
    chk({tag, "_frame_pending"}, 64'(frame_pending), 64'(pend));
    chk({tag, "_drop_count"}, 64'(drop_count), 64'(drops));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge where the resulting buf_we pulse is visible.
  task automatic send_record(input logic [4:0][15:0] w, input logic [2:0] we,
                             input logic [9:0] col, input logic [41:0] cd, input logic [31:0] sf);
    for (int i = 0; i < 5; i++) begin
      word_valid = 1'b1;
      wr_word    = w[i];
      if (i == 4) sb.push_back('{we: we, col: col, cd: cd, sf: sf});
      @(negedge clk);
    end
    word_valid = 1'b0;
  endtask

  task automatic send_words(input int n);
    for (int i = 0; i < n; i++) begin
      word_valid = 1'b1;
      wr_word    = 16'($urandom);
      @(negedge clk);
    end
    word_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [2:0] we, input int ncols);
    logic [4:0][15:0] w;
    for (int c = 0; c < ncols; c++) begin
      for (int k = 0; k < 5; k++) w[k] = 16'($urandom);
      send_record(w, we, 10'(c), {w[2], w[1], w[0][9:0]}, {w[3], w[4]});
    end
  endtask

  task automatic pulse_swap();
    swap_strobe = 1'b1;
    @(negedge clk);
    swap_strobe = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{w: {16'hBEEF, 16'h1234, 16'h5555, 16'hAAAA, 16'h0123},
                cd: {16'h5555, 16'hAAAA, 10'h123}, sf: 32'h1234BEEF};
    vecs[1] = '{w: {16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF},
                cd: {16'hFFFF, 16'h0000, 10'h3FF}, sf: 32'h0000FFFF};
    vecs[2] = '{w: {16'hC0DE, 16'hDEAD, 16'h2468, 16'h1357, 16'hFC00},
                cd: {16'h2468, 16'h1357, 10'h000}, sf: 32'hDEADC0DE};
    vecs[3] = '{w: {16'hF00D, 16'hCAFE, 16'h7FFE, 16'h8001, 16'h02A5},
                cd: {16'h7FFE, 16'h8001, 10'h2A5}, sf: 32'hCAFEF00D};

    reset_n     = 1'b0;
    word_valid  = 1'b0;
    wr_word     = 16'h0;
    col_restart = 1'b0;
    swap_strobe = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Table vectors: consecutive columns of buffer 1, with hold check afterwards.
    for (int i = 0; i < 4; i++) begin
      send_record(vecs[i].w, 3'b010, 10'(i), vecs[i].cd, vecs[i].sf);
      repeat (2) @(negedge clk);
      chk("hold_buf_we", 64'(buf_we), 64'(0));
      chk("hold_coldata", 64'(wr_coldata), 64'(vecs[i].cd));
      chk("hold_sfdata", 64'(wr_sfdata), 64'(vecs[i].sf));
    end

    // Single frame, then display swap.
    do_reset();
    send_frame(3'b010, 640);
    chk("frame_end_wr_old", 64'(wr_idx), 64'(1));
    @(negedge clk);
    check_roles("frame1", 2'd0, 2'd2, 2'd1, 1'b1, 8'd0);
    pulse_swap();
    check_roles("swap1", 2'd1, 2'd2, 2'd0, 1'b0, 8'd0);
    pulse_swap();
    check_roles("swap_idle", 2'd1, 2'd2, 2'd0, 1'b0, 8'd0);

    // Two frames without a swap drop the older one.
    do_reset();
    send_frame(3'b010, 640);
    @(negedge clk);
    send_frame(3'b100, 640);
    @(negedge clk);
    check_roles("drop", 2'd0, 2'd1, 2'd2, 1'b1, 8'd1);
    pulse_swap();
    check_roles("drop_swap", 2'd2, 2'd1, 2'd0, 1'b0, 8'd1);

    // Frame end coincident with swap_strobe, nothing pending.
    do_reset();
    send_frame(3'b010, 640);
    pulse_swap();
    check_roles("coinc_nopend", 2'd1, 2'd2, 2'd0, 1'b0, 8'd0);

    // Frame end coincident with swap_strobe while a frame is pending.
    do_reset();
    send_frame(3'b010, 640);
    @(negedge clk);
    send_frame(3'b100, 640);
    pulse_swap();
    check_roles("coinc_pend", 2'd2, 2'd1, 2'd0, 1'b0, 8'd1);

    // Restart mid-record, with a word in the same cycle that must be ignored.
    do_reset();
    send_record(vecs[1].w, 3'b010, 10'd0, vecs[1].cd, vecs[1].sf);
    send_words(3);
    col_restart = 1'b1;
    word_valid  = 1'b1;
    wr_word     = 16'hFFFF;
    @(negedge clk);
    col_restart = 1'b0;
    word_valid  = 1'b0;
    send_record(vecs[2].w, 3'b010, 10'd0, vecs[2].cd, vecs[2].sf);
    repeat (6) @(negedge clk);

    // Asynchronous reset mid-frame and mid-record.
    do_reset();
    send_frame(3'b010, 300);
    send_words(2);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check_reset_vals("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    send_record(vecs[3].w, 3'b010, 10'd0, vecs[3].cd, vecs[3].sf);

    repeat (4) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
